eth_tx_mii: RTL and testbench

Ethernet MII transmit engine that drains the 32-bit transmit-data FIFO filled by the Wishbone host interface and serialises one frame per start command onto a 4-bit MII transmit bus. Generates preamble and SFD, streams the payload least-significant nibble first, zero-pads to the 60-byte minimum, and appends the CRC-32 FCS. Enforces the 96-bit-time inter-frame gap. Runs entirely in the MII transmit clock domain, with one nibble per `clk`.

---
 rtl/eth_tx_mii.sv | 209 ++++++++++++++++++++
 tb/tb_eth_tx_mii.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_mii.sv
// Ethernet MII transmit engine: serialises one frame per start command from the
// 32-bit transmit FIFO onto the 4-bit MII bus with preamble, SFD, minimum-size
// padding, CRC-32 FCS and the 96-bit-time inter-frame gap.
module eth_tx_mii (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [8:0]  i_word_count,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_rd,
  output logic [3:0]  o_txd,
  output logic        o_tx_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [8:0]  words_q, words_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] crc_q, crc_d;
  logic        pop_q, pop_d;
  logic        done_q, done_d;
  logic        last_word;
  logic        pop_due;
  logic        underrun;

  // One nibble of the reflected CRC-32, consuming bit 0 first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] crc_in, input logic [3:0] nib);
    logic [31:0] c;
    c = crc_in ^ {28'h0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Decide whether a word prefetch is due this cycle and whether the FIFO can supply it.
  always_comb begin
    last_word = (cnt_q[11:3] == (words_q - 9'd1));
    pop_due   = 1'b0;
    if (!rst) begin
      if (state_q == PREAMBLE && cnt_q == 12'd14) begin
        pop_due = 1'b1;
      end
      if (state_q == DATA && cnt_q[2:0] == 3'd6 && !last_word) begin
        pop_due = 1'b1;
      end
    end
    underrun = pop_due & i_fifo_empty;
  end

  assign o_fifo_rd  = pop_due & ~i_fifo_empty;
  assign o_underrun = underrun;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;

  // Drive the MII bus purely from registered state so TXD only moves on clock edges.
  always_comb begin
    o_txd   = 4'h0;
    o_tx_en = 1'b0;
    case (state_q)
      PREAMBLE: begin
        o_tx_en = 1'b1;
        o_txd   = 4'h5;
      end
      SFD: begin
        o_tx_en = 1'b1;
        o_txd   = 4'hD;
      end
      DATA: begin
        o_tx_en = 1'b1;
        o_txd   = shift_q[3:0];
      end
      PAD: begin
        o_tx_en = 1'b1;
        o_txd   = 4'h0;
      end
      FCS: begin
        o_tx_en = 1'b1;
        o_txd   = ~crc_q[3:0];
      end
      default: begin
        o_txd   = 4'h0;
        o_tx_en = 1'b0;
      end
    endcase
  end

  // Next-state logic: frame sequencing, nibble counting, word shifting and CRC update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    shift_d = shift_q;
    crc_d   = crc_q;
    pop_d   = o_fifo_rd;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && i_word_count != 9'd0) begin
          state_d = PREAMBLE;
          cnt_d   = 12'd0;
          words_d = i_word_count;
          crc_d   = 32'hFFFFFFFF;
        end
      end
      PREAMBLE: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'd14) begin
          state_d = SFD;
          cnt_d   = 12'd0;
        end
      end
      SFD: begin
        state_d = DATA;
        cnt_d   = 12'd0;
      end
      DATA: begin
        crc_d   = crc_nibble(crc_q, shift_q[3:0]);
        cnt_d   = cnt_q + 12'd1;
        shift_d = {4'h0, shift_q[31:4]};
        if (cnt_q[2:0] == 3'd7 && last_word) begin
          if (words_q < 9'd15) begin
            state_d = PAD;
          end else begin
            state_d = FCS;
            cnt_d   = 12'd0;
          end
        end
      end
      PAD: begin
        crc_d = crc_nibble(crc_q, 4'h0);
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'd119) begin
          state_d = FCS;
          cnt_d   = 12'd0;
        end
      end
      FCS: begin
        crc_d = {4'hF, crc_q[31:4]};
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'd7) begin
          state_d = IFG;
          cnt_d   = 12'd0;
          done_d  = 1'b1;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'd23) begin
          state_d = IDLE;
          cnt_d   = 12'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 12'd0;
      end
    endcase

    // A word popped last cycle lands in the shift register just as the previous one empties.
    if (pop_q) begin
      shift_d = i_fifo_data;
    end

    // A missing word aborts the frame without FCS and goes straight to the gap.
    if (underrun) begin
      state_d = IFG;
      cnt_d   = 12'd0;
      done_d  = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 12'd0;
      words_q <= 9'd0;
      shift_q <= 32'd0;
      crc_q   <= 32'hFFFFFFFF;
      pop_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      shift_q <= shift_d;
      crc_q   <= crc_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_mii.sv
// Self-checking bench for eth_tx_mii: a scoreboard of expected MII nibbles built
// from a byte-wise CRC model, a FIFO model, and per-scenario timing checks.
module tb_eth_tx_mii;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [8:0]  i_word_count = 9'd0;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_data = 32'd0;
  logic        o_fifo_rd;
  logic [3:0]  o_txd;
  logic        o_tx_en;
  logic        o_busy;
  logic        o_done;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [31:0] frame_words [0:31];

  logic [3:0] exp_q[$];
  logic [3:0] rx_q[$];
  int         pop_log[$];
  int         done_log[$];
  int         urun_log[$];
  int         rise_log[$];
  int         fall_log[$];
  int         tx_total = 0;
  bit         prev_en = 1'b0;

  eth_tx_mii dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_txd        (o_txd),
    .o_tx_en      (o_tx_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_underrun   (o_underrun)
  );

  always #5 clk = ~clk;

  // Cycle counter, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: read data appears the cycle after a pop.
  assign i_fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (o_fifo_rd === 1'b1 && rd_ptr != wr_ptr) begin
      i_fifo_data <= fifo_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Monitor: compare each transmitted nibble against the scoreboard and log events.
  always @(negedge clk) begin
    if (o_tx_en === 1'b1) begin
      tx_total++;
      rx_q.push_back(o_txd);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_tx cyc=%0d got txd=%h expected no transmission", cyc, o_txd);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (o_txd !== e) begin
          errors++;
          $display("[TB] FAIL txd_nibble cyc=%0d got %h expected %h", cyc, o_txd, e);
        end
      end
    end else begin
      checks++;
      if (o_txd !== 4'h0 || o_tx_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL txd_idle cyc=%0d got txd=%h en=%b expected 0", cyc, o_txd, o_tx_en);
      end
    end
    if (o_tx_en === 1'b1 && !prev_en) rise_log.push_back(cyc);
    if (o_tx_en !== 1'b1 && prev_en) fall_log.push_back(cyc);
    prev_en = (o_tx_en === 1'b1);
    if (o_fifo_rd === 1'b1) pop_log.push_back(cyc);
    if (o_done === 1'b1) done_log.push_back(cyc);
    if (o_underrun === 1'b1) urun_log.push_back(cyc);
  end

  // Reference CRC, one byte at a time, low bit first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Nibble-wise CRC used for the residue check over the received stream.
  function automatic logic [31:0] crc_nib(input logic [31:0] c_in, input logic [3:0] n);
    logic [31:0] c;
    c = c_in ^ {28'h0, n};
    for (int i = 0; i < 4; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic load_word(input logic [31:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Push the expected nibble stream; keep<0 means a whole frame, else only that many payload nibbles.
  task automatic push_frame(input int n, input int keep);
    logic [7:0]  bytes[$];
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [31:0] w;
    int          total;
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    for (int k = 0; k < n; k++) begin
      w = frame_words[k];
      for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
    end
    while (bytes.size() < 60) bytes.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < bytes.size(); i++) crc = crc_byte(crc, bytes[i]);
    fcs = ~crc;
    total = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (keep < 0 || total < keep) exp_q.push_back(bytes[i][3:0]);
      total++;
      if (keep < 0 || total < keep) exp_q.push_back(bytes[i][7:4]);
      total++;
    end
    if (keep < 0) begin
      for (int j = 0; j < 8; j++) exp_q.push_back(fcs[4*j +: 4]);
    end
  endtask

  task automatic start_frame(input int n, input bit hold, output int t0);
    @(negedge clk);
    i_start      = 1'b1;
    i_word_count = n[8:0];
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!hold) i_start = 1'b0;
  endtask

  task automatic wait_not_busy(input int limit, output int end_cyc, output bit ok);
    ok      = 1'b0;
    end_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (o_busy === 1'b0) begin
        ok      = 1'b1;
        end_cyc = cyc;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    i_start      = 1'b1;
    i_word_count = 9'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({o_fifo_rd, o_txd, o_tx_en, o_busy, o_done, o_underrun} !== 9'h000) begin
        errors++;
        $display("[TB] FAIL reset_outputs edge=%0d got %b expected all zero", i,
                 {o_fifo_rd, o_txd, o_tx_en, o_busy, o_done, o_underrun});
      end
    end
    rst     = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (pop_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_pop got %0d pops expected 0", pop_log.size());
    end
  endtask

  task automatic test_single_padded();
    int t0, end_cyc, pb, db, ub, rb, tb0;
    bit ok;
    logic [31:0] r;
    frame_words[0] = 32'h44332211;
    load_word(32'h44332211);
    push_frame(1, -1);
    pb = pop_log.size(); db = done_log.size(); ub = urun_log.size(); rb = rx_q.size(); tb0 = tx_total;
    start_frame(1, 1'b0, t0);
    wait_not_busy(400, end_cyc, ok);
    checks++;
    if (!ok || end_cyc != t0 + 168) begin
      errors++;
      $display("[TB] FAIL single_busy_end got %0d expected 168", end_cyc - t0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL single_scoreboard got %0d left expected 0", exp_q.size());
    end
    checks++;
    if (pop_log.size() - pb != 1 || pop_log[pb] != t0 + 14) begin
      errors++;
      $display("[TB] FAIL single_pop got %0d pops expected 1 at cycle 15", pop_log.size() - pb);
    end
    checks++;
    if (tx_total - tb0 != 144) begin
      errors++;
      $display("[TB] FAIL single_tx_en_len got %0d expected 144", tx_total - tb0);
    end
    checks++;
    if (done_log.size() - db != 1 || done_log[db] != t0 + 144) begin
      errors++;
      $display("[TB] FAIL single_done got %0d pulses expected 1 at cycle 145", done_log.size() - db);
    end
    checks++;
    if (urun_log.size() != ub) begin
      errors++;
      $display("[TB] FAIL single_underrun got %0d expected 0", urun_log.size() - ub);
    end
    r = 32'hFFFFFFFF;
    for (int i = rb + 16; i < rb + 16 + 128; i++) r = crc_nib(r, rx_q[i]);
    checks++;
    if (r !== 32'hDEBB20E3) begin
      errors++;
      $display("[TB] FAIL single_residue got %h expected DEBB20E3", r);
    end
  endtask

  task automatic test_unpadded();
    int t0, end_cyc, pb, db, rb, tb0, bad;
    bit ok;
    logic [31:0] r;
    logic [7:0] b;
    for (int k = 0; k < 20; k++) begin
      b = 8'(4 * k);
      frame_words[k] = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      load_word(frame_words[k]);
    end
    push_frame(20, -1);
    pb = pop_log.size(); db = done_log.size(); rb = rx_q.size(); tb0 = tx_total;
    start_frame(20, 1'b0, t0);
    wait_not_busy(500, end_cyc, ok);
    checks++;
    if (!ok || end_cyc != t0 + 208) begin
      errors++;
      $display("[TB] FAIL unpadded_busy_end got %0d expected 208", end_cyc - t0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL unpadded_scoreboard got %0d left expected 0", exp_q.size());
    end
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      if (pb + j >= pop_log.size() || pop_log[pb + j] != t0 + 14 + 8 * j) bad++;
    end
    checks++;
    if (pop_log.size() - pb != 20 || bad != 0) begin
      errors++;
      $display("[TB] FAIL unpadded_pops got %0d pops with %0d mistimed expected 20 on time",
               pop_log.size() - pb, bad);
    end
    checks++;
    if (tx_total - tb0 != 184) begin
      errors++;
      $display("[TB] FAIL unpadded_tx_en_len got %0d expected 184", tx_total - tb0);
    end
    checks++;
    if (done_log.size() - db != 1 || done_log[db] != t0 + 184) begin
      errors++;
      $display("[TB] FAIL unpadded_done got %0d pulses expected 1 at cycle 185", done_log.size() - db);
    end
    r = 32'hFFFFFFFF;
    for (int i = rb + 16; i < rb + 16 + 168; i++) r = crc_nib(r, rx_q[i]);
    checks++;
    if (r !== 32'hDEBB20E3) begin
      errors++;
      $display("[TB] FAIL unpadded_residue got %h expected DEBB20E3", r);
    end
  endtask

  task automatic test_underrun();
    int t0, end_cyc, pb, db, ub, fb, tb0;
    bit ok;
    frame_words[0] = 32'hA1B2C3D4;
    frame_words[1] = 32'h0F1E2D3C;
    frame_words[2] = 32'h11111111;
    frame_words[3] = 32'h22222222;
    load_word(frame_words[0]);
    load_word(frame_words[1]);
    push_frame(4, 15);
    pb = pop_log.size(); db = done_log.size(); ub = urun_log.size(); fb = fall_log.size(); tb0 = tx_total;
    start_frame(4, 1'b0, t0);
    wait_not_busy(200, end_cyc, ok);
    checks++;
    if (urun_log.size() - ub != 1 || urun_log[ub] != t0 + 30) begin
      errors++;
      $display("[TB] FAIL underrun_pulse got %0d pulses expected 1 at cycle 31", urun_log.size() - ub);
    end
    checks++;
    if (pop_log.size() - pb != 2) begin
      errors++;
      $display("[TB] FAIL underrun_pops got %0d expected 2", pop_log.size() - pb);
    end
    checks++;
    if (tx_total - tb0 != 31 || fall_log.size() - fb != 1 || fall_log[fb] != t0 + 31) begin
      errors++;
      $display("[TB] FAIL underrun_tx_stop got %0d tx cycles expected 31", tx_total - tb0);
    end
    checks++;
    if (done_log.size() != db) begin
      errors++;
      $display("[TB] FAIL underrun_no_done got %0d expected 0", done_log.size() - db);
    end
    checks++;
    if (!ok || end_cyc != t0 + 55) begin
      errors++;
      $display("[TB] FAIL underrun_busy_end got %0d expected 55", end_cyc - t0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL underrun_scoreboard got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_start_rules();
    int t0, end_cyc, pb, db, tb0, rb0, fb;
    bit ok, seen_busy;
    // Zero-length request is ignored.
    pb = pop_log.size(); tb0 = tx_total;
    start_frame(0, 1'b0, t0);
    seen_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_busy !== 1'b0) seen_busy = 1'b1;
    end
    #1;
    checks++;
    if (seen_busy || tx_total != tb0 || pop_log.size() != pb) begin
      errors++;
      $display("[TB] FAIL zero_count_start got busy=%b tx=%0d pops=%0d expected 0 0 0",
               seen_busy, tx_total - tb0, pop_log.size() - pb);
    end

    // Start pulsed mid-frame is ignored.
    frame_words[0] = 32'h0A0B0C0D;
    load_word(frame_words[0]);
    push_frame(1, -1);
    pb = pop_log.size(); db = done_log.size(); tb0 = tx_total;
    start_frame(1, 1'b0, t0);
    repeat (30) @(negedge clk);
    i_start      = 1'b1;
    i_word_count = 9'd5;
    @(negedge clk);
    i_start      = 1'b0;
    wait_not_busy(400, end_cyc, ok);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (!ok || end_cyc != t0 + 168 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midframe_start_busy got end %0d expected 168", end_cyc - t0);
    end
    checks++;
    if (tx_total - tb0 != 144 || pop_log.size() - pb != 1 || done_log.size() - db != 1) begin
      errors++;
      $display("[TB] FAIL midframe_start_frame got tx=%0d pops=%0d done=%0d expected 144 1 1",
               tx_total - tb0, pop_log.size() - pb, done_log.size() - db);
    end

    // Start held high gives two frames with the full gap between them.
    frame_words[0] = 32'h87654321;
    load_word(frame_words[0]);
    push_frame(1, -1);
    frame_words[0] = 32'hCAFEF00D;
    load_word(frame_words[0]);
    push_frame(1, -1);
    pb = pop_log.size(); db = done_log.size(); tb0 = tx_total; rb0 = rise_log.size(); fb = fall_log.size();
    start_frame(1, 1'b1, t0);
    repeat (175) @(negedge clk);
    i_start = 1'b0;
    wait_not_busy(400, end_cyc, ok);
    checks++;
    if (rise_log.size() - rb0 != 2 || fall_log.size() - fb != 2 ||
        rise_log[rb0] != t0 || fall_log[fb] != t0 + 144 || rise_log[rb0 + 1] - fall_log[fb] != 25) begin
      errors++;
      $display("[TB] FAIL back_to_back_gap got %0d frames expected 2 separated by 25 low cycles",
               rise_log.size() - rb0);
    end
    checks++;
    if (tx_total - tb0 != 288 || pop_log.size() - pb != 2 || done_log.size() - db != 2) begin
      errors++;
      $display("[TB] FAIL back_to_back_frames got tx=%0d pops=%0d done=%0d expected 288 2 2",
               tx_total - tb0, pop_log.size() - pb, done_log.size() - db);
    end
    checks++;
    if (!ok || end_cyc != t0 + 337 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL back_to_back_end got %0d left=%0d expected 337 0", end_cyc - t0, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int t0, end_cyc, pb, db, rb, tb0;
    bit ok;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      frame_words[k] = 32'h10203040 + 32'(k);
      load_word(frame_words[k]);
    end
    push_frame(4, 27);
    pb = pop_log.size();
    start_frame(4, 1'b0, t0);
    repeat (43) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_tx_en !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_drop got en=%b busy=%b expected 0 0", o_tx_en, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (pop_log.size() - pb != 4 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_prefix got pops=%0d left=%0d expected 4 0", pop_log.size() - pb, exp_q.size());
    end

    frame_words[0] = 32'hDEADBEEF;
    load_word(frame_words[0]);
    push_frame(1, -1);
    db = done_log.size(); rb = rx_q.size(); tb0 = tx_total;
    start_frame(1, 1'b0, t0);
    wait_not_busy(400, end_cyc, ok);
    checks++;
    if (!ok || end_cyc != t0 + 168 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL postreset_frame got end=%0d left=%0d expected 168 0", end_cyc - t0, exp_q.size());
    end
    checks++;
    if (tx_total - tb0 != 144 || done_log.size() - db != 1) begin
      errors++;
      $display("[TB] FAIL postreset_len got tx=%0d done=%0d expected 144 1", tx_total - tb0, done_log.size() - db);
    end
    r = 32'hFFFFFFFF;
    for (int i = rb + 16; i < rb + 16 + 128; i++) r = crc_nib(r, rx_q[i]);
    checks++;
    if (r !== 32'hDEBB20E3) begin
      errors++;
      $display("[TB] FAIL postreset_residue got %h expected DEBB20E3", r);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_padded();
    test_unpadded();
    test_underrun();
    test_start_rules();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a scenario stalls outside its own limits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
